serial_sub8: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/serial_sub8_full_sub1.sv | 14 +
 rtl/serial_sub8.sv | 157 +++++++++++++++
 tb/tb_serial_sub8.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// FSM state encoding and the default operand width.
package serial_sub_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub8_full_sub1.sv
// Combinational 1-bit full subtractor: d = a - b - bin.
// bout is the borrow propagated to the next bit.
module full_sub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial subtractor, LSB first, valid/ready on both sides.
// Define SERSUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub8
  import serial_sub_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH:0]   diff_q, diff_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             d_bit;
  logic             bout;
  logic             last_bit;

`ifdef SERSUB_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  full_sub1 u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (bout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    br_d        = br_q;
    diff_d      = diff_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SERSUB_OVF_EN
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          br_d       = bin;
          res_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
`ifdef SERSUB_OVF_EN
          a_msb_d    = a[WIDTH-1];
          b_msb_d    = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = bout;
        res_d = {d_bit, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last_bit) begin
          // d_bit is the result MSB on the final bit-cycle
          diff_d      = {bout, d_bit, res_q[WIDTH-1:1]};
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef SERSUB_OVF_EN
          ovf_d = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      diff_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERSUB_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      br_q        <= br_d;
      diff_q      <= diff_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SERSUB_OVF_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
`ifdef SERSUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub8.sv
// Randomized and directed bench for serial_sub8.
// Reference results come from plain integer subtraction.
module tb_serial_sub8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] diff;
`ifdef SERSUB_OVF_EN
  logic       ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc    = 0;
  int acc_prev = 0;

  serial_sub8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff)
`ifdef SERSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_diff(input logic [7:0] x,
                                          input logic [7:0] y,
                                          input logic       c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return r[8:0];
  endfunction

  function automatic logic ref_ovf(input logic [7:0] x,
                                   input logic [7:0] y,
                                   input logic       c);
    int s;
    s = int'($signed(x)) - int'($signed(y)) - int'(c);
    return (s < -128) || (s > 127);
  endfunction

  // Present operands, wait for acceptance, return one negedge later.
  task automatic issue(input logic [7:0] x,
                       input logic [7:0] y,
                       input logic       c,
                       input bit         keep);
    int t;
    in_valid = 1'b1;
    a = x;
    b = y;
    bin = c;
    t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", 32'(t < 40), 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc_prev = acc;
    acc = cyc;
    if (!keep) in_valid = 1'b0;
    check("in_ready_run", 32'(in_ready), 32'd0);
  endtask

  task automatic collect(input logic [7:0] x,
                         input logic [7:0] y,
                         input logic       c,
                         input int         stall);
    logic [8:0] exp_d;
    exp_d = ref_diff(x, y, c);
    while (!out_valid && (cyc - acc) < 40) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    out_ready = (stall == 0);
    check("latency", 32'(cyc - acc), 32'd8);
    check("out_valid", 32'(out_valid), 32'd1);
    check("diff", 32'(diff), 32'(exp_d));
`ifdef SERSUB_OVF_EN
    check("ovf", 32'(ovf), 32'(ref_ovf(x, y, c)));
`endif
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_diff", 32'(diff), 32'(exp_d));
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handoff_valid", 32'(out_valid), 32'd0);
    check("handoff_in_ready", 32'(in_ready), 32'd1);
    check("hold_diff", 32'(diff), 32'(exp_d));
  endtask

  initial begin
    int seen;
    logic [7:0] ra, rb;
    logic rc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
`ifdef SERSUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'hFF, 8'hFF, 1'b0, 1'b0);
    collect(8'hFF, 8'hFF, 1'b0, 0);
    check("ff_ff", 32'(diff), 32'h000);

    issue(8'h79, 8'h69, 1'b0, 1'b1);
    a = 8'h79;
    b = 8'h6B;
    collect(8'h79, 8'h69, 1'b0, 0);
    check("d79_69", 32'(diff), 32'h010);
    issue(8'h79, 8'h6B, 1'b0, 1'b0);
    check("b2b_gap", 32'(acc - acc_prev), 32'd10);
    collect(8'h79, 8'h6B, 1'b0, 0);
    check("d79_6b", 32'(diff), 32'h00E);

    issue(8'h00, 8'h01, 1'b0, 1'b0);
    collect(8'h00, 8'h01, 1'b0, 5);
    check("borrow_out", 32'(diff), 32'h1FF);
    issue(8'h00, 8'h00, 1'b1, 1'b0);
    collect(8'h00, 8'h00, 1'b1, 0);
    check("borrow_in", 32'(diff), 32'h1FF);

    issue(8'h55, 8'h12, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_result", 32'(seen), 32'd0);
    issue(8'h10, 8'h01, 1'b0, 1'b0);
    collect(8'h10, 8'h01, 1'b0, 0);
    check("post_rst", 32'(diff), 32'h00F);

`ifdef SERSUB_OVF_EN
    issue(8'h80, 8'h01, 1'b0, 1'b0);
    collect(8'h80, 8'h01, 1'b0, 0);
    check("ovf_80_01", 32'(ovf), 32'd1);
    check("ovf_80_01_d", 32'(diff), 32'h07F);
    issue(8'h05, 8'h03, 1'b0, 1'b0);
    collect(8'h05, 8'h03, 1'b0, 0);
    check("ovf_05_03", 32'(ovf), 32'd0);
`endif

    for (int k = 0; k < 24; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(ra, rb, rc, 1'b0);
      a = 8'($urandom);
      b = 8'($urandom);
      collect(ra, rb, rc, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
